// File: rtl/dict_ctrl_pkg.sv
// Shared types and helpers for the dictionary write controller.
package dict_ctrl_pkg;

  // Widest lane count the rank helper is sized for
  localparam int MAX_LANES = 8;

  // Match-type codes produced by the type-decode stage
  typedef enum logic [1:0] {
    TYPE_NONE     = 2'd0,
    TYPE_PARTIAL  = 2'd1,
    TYPE_FULL     = 2'd2,
    TYPE_RESERVED = 2'd3
  } match_type_e;

  // Controller states
  typedef enum logic [1:0] {
    FILLING = 2'd0,
    FULL    = 2'd1,
    FLUSH   = 2'd2
  } ctrl_state_e;

  // Popcount of the need bits strictly below lane k; k = lane count gives the total
  function automatic logic [3:0] rank_below(input logic [MAX_LANES-1:0] need, input int k);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < k) cnt = cnt + {3'b000, need[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lane_rank_prefix.sv
// Combinational prefix popcount: each lane's rank among the lanes that need a write.
module lane_rank_prefix
  import dict_ctrl_pkg::*;
#(
  parameter int  NUM_LANES = 2,
  localparam int CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0]            need,
  output logic [NUM_LANES-1:0][CNT_W-1:0] rank,
  output logic [CNT_W-1:0]                total
);

  logic [MAX_LANES-1:0] need_ext;

  // Zero-extend the need vector and rank every lane against the lanes before it
  always_comb begin
    need_ext = '0;
    need_ext[NUM_LANES-1:0] = need;
    for (int k = 0; k < NUM_LANES; k++) begin
      rank[k] = CNT_W'(rank_below(need_ext, k));
    end
    total = CNT_W'(rank_below(need_ext, NUM_LANES));
  end

endmodule

// File: rtl/dict_write_ctrl.sv
// Dictionary write controller: per-lane write enables/addresses, replacement
// pointer and fill level, registered behind a valid/ready handshake.
module dict_write_ctrl
  import dict_ctrl_pkg::*;
#(
  parameter int  NUM_LANES  = 2,
  parameter int  TYPE_W     = 2,
  parameter int  DICT_DEPTH = 16,
  localparam int ADDR_W     = $clog2(DICT_DEPTH),
  localparam int CNT_W      = $clog2(NUM_LANES + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [NUM_LANES*TYPE_W-1:0] i_type_matched,
  input  logic [NUM_LANES-1:0]        i_match,
  input  logic                        i_flush,
  input  logic                        i_freeze_on_full,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [NUM_LANES-1:0]        o_wr_en,
  output logic [NUM_LANES*ADDR_W-1:0] o_wr_addr,
  output logic [CNT_W-1:0]            o_wr_count,
  output logic [ADDR_W:0]             o_fill_level,
  output logic                        o_dict_full
);

  localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DICT_DEPTH);

  ctrl_state_e                     state;
  logic [ADDR_W-1:0]               ptr;
  logic                            ready_armed;
  logic                            accept;
  logic [NUM_LANES-1:0]            need;
  logic [NUM_LANES-1:0][CNT_W-1:0] rank;
  logic [CNT_W-1:0]                need_total;
  logic [ADDR_W:0]                 room;
  logic [NUM_LANES-1:0]            wr_en_nxt;
  logic [NUM_LANES*ADDR_W-1:0]     wr_addr_nxt;
  logic [CNT_W-1:0]                wr_cnt_nxt;
  logic [31:0]                     fill_sum;
  logic [ADDR_W:0]                 fill_nxt;
  logic [ADDR_W-1:0]               ptr_nxt;

  // A lane needs a dictionary slot when it neither matched by type nor hit earlier
  always_comb begin
    need = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      need[k] = (i_type_matched[k*TYPE_W +: TYPE_W] == TYPE_W'(TYPE_NONE)) & ~i_match[k];
    end
  end

  lane_rank_prefix #(
    .NUM_LANES(NUM_LANES)
  ) u_rank (
    .need (need),
    .rank (rank),
    .total(need_total)
  );

  assign o_ready = ready_armed & (state != FLUSH) & ~i_flush & (~o_valid | i_ready);
  assign accept  = i_valid & o_ready;

  // Decode the beat: enables, addresses, write count and the updated ptr/fill
  always_comb begin
    wr_en_nxt   = '0;
    wr_addr_nxt = '0;
    room        = FILL_MAX - o_fill_level;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (need[k] && (!i_freeze_on_full ||
                      (32'(o_fill_level) + 32'(rank[k])) < 32'(DICT_DEPTH))) begin
        wr_en_nxt[k] = 1'b1;
        wr_addr_nxt[k*ADDR_W +: ADDR_W] = ptr + ADDR_W'(rank[k]);
      end
    end
    if (i_freeze_on_full && (32'(need_total) > 32'(room))) begin
      wr_cnt_nxt = CNT_W'(room);
    end else begin
      wr_cnt_nxt = need_total;
    end
    fill_sum = 32'(o_fill_level) + 32'(wr_cnt_nxt);
    fill_nxt = (fill_sum >= 32'(DICT_DEPTH)) ? FILL_MAX : fill_sum[ADDR_W:0];
    ptr_nxt  = ptr + ADDR_W'(wr_cnt_nxt);
  end

  // State machine, ptr/fill counters and the registered output beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= FILLING;
      ptr          <= '0;
      ready_armed  <= 1'b0;
      o_valid      <= 1'b0;
      o_wr_en      <= '0;
      o_wr_addr    <= '0;
      o_wr_count   <= '0;
      o_fill_level <= '0;
      o_dict_full  <= 1'b0;
    end else begin
      ready_armed <= 1'b1;
      if (i_flush) begin
        state        <= FLUSH;
        ptr          <= '0;
        o_valid      <= 1'b0;
        o_wr_en      <= '0;
        o_wr_addr    <= '0;
        o_wr_count   <= '0;
        o_fill_level <= '0;
        o_dict_full  <= 1'b0;
      end else if (state == FLUSH) begin
        state <= FILLING;
      end else if (accept) begin
        state        <= (fill_nxt == FILL_MAX) ? FULL : FILLING;
        ptr          <= ptr_nxt;
        o_valid      <= 1'b1;
        o_wr_en      <= wr_en_nxt;
        o_wr_addr    <= wr_addr_nxt;
        o_wr_count   <= wr_cnt_nxt;
        o_fill_level <= fill_nxt;
        o_dict_full  <= (fill_nxt == FILL_MAX);
      end else if (i_ready) begin
        o_valid    <= 1'b0;
        o_wr_en    <= '0;
        o_wr_addr  <= '0;
        o_wr_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dict_write_ctrl.sv
// Randomized self-checking bench for dict_write_ctrl against a behavioural model.
module tb_dict_write_ctrl;

  localparam int NL    = 2;
  localparam int TW    = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [NL*TW-1:0] i_type_matched = '0;
  logic [NL-1:0]   i_match = '0;
  logic            i_flush = 1'b0;
  logic            i_freeze_on_full = 1'b0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [NL-1:0]   o_wr_en;
  logic [NL*AW-1:0] o_wr_addr;
  logic [CW-1:0]   o_wr_count;
  logic [AW:0]     o_fill_level;
  logic            o_dict_full;

  always #5 clk = ~clk;

  dict_write_ctrl #(
    .NUM_LANES (NL),
    .TYPE_W    (TW),
    .DICT_DEPTH(DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_type_matched  (i_type_matched),
    .i_match         (i_match),
    .i_flush         (i_flush),
    .i_freeze_on_full(i_freeze_on_full),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_wr_en         (o_wr_en),
    .o_wr_addr       (o_wr_addr),
    .o_wr_count      (o_wr_count),
    .o_fill_level    (o_fill_level),
    .o_dict_full     (o_dict_full)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int            ref_ptr, ref_fill, ref_cnt;
  bit            ref_valid, ref_flushing, ref_armed;
  logic [NL-1:0] ref_en;
  logic [NL*AW-1:0] ref_addr;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit modelReady();
    return ref_armed && !ref_flushing && !i_flush && (!ref_valid || i_ready);
  endfunction

  task automatic modelReset();
    ref_ptr = 0; ref_fill = 0; ref_cnt = 0;
    ref_valid = 0; ref_flushing = 0; ref_armed = 0;
    ref_en = '0; ref_addr = '0;
  endtask

  // Compare every visible output against the model mid-cycle
  task automatic checkCycle();
    checkOutput("o_ready", o_ready, modelReady());
    checkOutput("o_valid", o_valid, ref_valid);
    checkOutput("o_fill_level", o_fill_level, ref_fill);
    checkOutput("o_dict_full", o_dict_full, ref_fill == DEPTH);
    if (ref_valid) begin
      checkOutput("o_wr_en", o_wr_en, ref_en);
      checkOutput("o_wr_addr", o_wr_addr, ref_addr);
      checkOutput("o_wr_count", o_wr_count, ref_cnt);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic modelEdge();
    bit acc;
    int needs;
    acc = i_valid && modelReady();
    if (i_flush) begin
      ref_ptr = 0; ref_fill = 0; ref_valid = 0; ref_flushing = 1;
    end else if (ref_flushing) begin
      ref_flushing = 0;
    end else if (acc) begin
      needs = 0;
      ref_cnt = 0;
      ref_en = '0;
      ref_addr = '0;
      for (int k = 0; k < NL; k++) begin
        if (i_type_matched[k*TW +: TW] == 0 && !i_match[k]) begin
          if (!i_freeze_on_full || (ref_fill + needs) < DEPTH) begin
            ref_en[k] = 1'b1;
            ref_addr[k*AW +: AW] = AW'((ref_ptr + needs) % DEPTH);
            ref_cnt++;
          end
          needs++;
        end
      end
      ref_ptr = (ref_ptr + ref_cnt) % DEPTH;
      ref_fill = (ref_fill + ref_cnt > DEPTH) ? DEPTH : ref_fill + ref_cnt;
      ref_valid = 1;
    end else if (i_ready) begin
      ref_valid = 0;
    end
    ref_armed = 1;
  endtask

  // Drive one cycle of inputs, check mid-cycle, then step past the edge
  task automatic applyStimulus(input bit v, input logic [NL*TW-1:0] t, input logic [NL-1:0] m,
                               input bit fl, input bit fr, input bit rd);
    i_valid = v; i_type_matched = t; i_match = m;
    i_flush = fl; i_freeze_on_full = fr; i_ready = rd;
    #3;
    checkCycle();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic randomBeat(input bit fr, input bit allow_flush);
    logic [NL*TW-1:0] t;
    logic [NL-1:0] m;
    for (int k = 0; k < NL; k++) begin
      t[k*TW +: TW] = ($urandom_range(0, 1) == 0) ? TW'(0) : TW'($urandom_range(0, 3));
      m[k] = ($urandom_range(0, 3) == 0);
    end
    applyStimulus($urandom_range(0, 3) != 0, t, m,
                  allow_flush && ($urandom_range(0, 49) == 0), fr, $urandom_range(0, 9) < 7);
  endtask

  initial begin
    bit freeze;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_o_valid", o_valid, 0);
    checkOutput("rst_o_wr_en", o_wr_en, 0);
    checkOutput("rst_o_wr_addr", o_wr_addr, 0);
    checkOutput("rst_o_wr_count", o_wr_count, 0);
    checkOutput("rst_o_fill_level", o_fill_level, 0);
    checkOutput("rst_o_dict_full", o_dict_full, 0);
    rst_n = 1'b1;
    applyStimulus(0, '0, '0, 0, 0, 1);
    checkOutput("ready_after_release", o_ready, 1);

    // Replace mode, ptr 0, both lanes miss
    applyStimulus(1, 4'h0, 2'b00, 0, 0, 1);
    checkOutput("tp1_en", o_wr_en, 2'b11);
    checkOutput("tp1_addr", o_wr_addr, {4'd1, 4'd0});
    checkOutput("tp1_cnt", o_wr_count, 2);
    checkOutput("tp1_fill", o_fill_level, 2);
    applyStimulus(1, 4'h0, 2'b00, 0, 0, 1);
    applyStimulus(1, 4'h0, 2'b10, 0, 0, 1);
    // Lane 0 partial match, lane 1 miss at ptr 5
    applyStimulus(1, {2'd0, 2'd1}, 2'b00, 0, 0, 1);
    checkOutput("tp2_en", o_wr_en, 2'b10);
    checkOutput("tp2_addr1", o_wr_addr[7:4], 5);
    applyStimulus(1, 4'h0, 2'b00, 0, 0, 1);
    checkOutput("tp2_ptr_follow", o_wr_addr, {4'd7, 4'd6});
    applyStimulus(1, 4'h0, 2'b10, 0, 0, 1);
    checkOutput("fill9", o_fill_level, 9);

    // Flush together with a valid beat at fill 9
    applyStimulus(1, 4'h0, 2'b00, 1, 0, 1);
    checkOutput("flush_valid", o_valid, 0);
    checkOutput("flush_fill", o_fill_level, 0);
    applyStimulus(0, 4'h0, 2'b00, 0, 0, 1);

    // Bring fill to 15, then freeze-mode boundary
    repeat (7) applyStimulus(1, 4'h0, 2'b00, 0, 0, 1);
    applyStimulus(1, 4'h0, 2'b10, 0, 0, 1);
    checkOutput("fill15", o_fill_level, 15);
    applyStimulus(1, 4'h0, 2'b00, 0, 1, 1);
    checkOutput("tp3_en", o_wr_en, 2'b01);
    checkOutput("tp3_addr0", o_wr_addr[3:0], 15);
    checkOutput("tp3_full", o_dict_full, 1);
    applyStimulus(1, 4'h0, 2'b00, 0, 1, 1);
    checkOutput("tp3_frozen_en", o_wr_en, 2'b00);
    checkOutput("tp3_frozen_valid", o_valid, 1);

    // Replace mode wrap at ptr 15 with a saturated fill
    repeat (7) applyStimulus(1, 4'h0, 2'b00, 0, 0, 1);
    applyStimulus(1, 4'h0, 2'b01, 0, 0, 1);
    applyStimulus(1, 4'h0, 2'b00, 0, 0, 1);
    checkOutput("tp4_addr", o_wr_addr, {4'd0, 4'd15});
    checkOutput("tp4_fill", o_fill_level, 16);

    // Downstream stall for three cycles with a beat waiting
    repeat (3) applyStimulus(1, 4'h0, 2'b00, 0, 0, 0);
    checkOutput("stall_ready", o_ready, 0);
    applyStimulus(1, 4'h0, 2'b00, 0, 0, 1);
    applyStimulus(1, 4'h0, 2'b00, 0, 0, 1);

    // Randomized traffic
    freeze = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) freeze = $urandom_range(0, 1);
      randomBeat(freeze, 1);
    end

    // Asynchronous reset in the middle of a beat
    i_valid = 1; i_type_matched = '0; i_match = '0; i_ready = 1; i_flush = 0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_o_valid", o_valid, 0);
    checkOutput("arst_o_wr_en", o_wr_en, 0);
    checkOutput("arst_o_wr_addr", o_wr_addr, 0);
    checkOutput("arst_o_wr_count", o_wr_count, 0);
    checkOutput("arst_o_fill", o_fill_level, 0);
    checkOutput("arst_o_full", o_dict_full, 0);
    checkOutput("arst_o_ready", o_ready, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 300; c++) randomBeat(c > 150, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dict_write_ctrl.md
# dict_write_ctrl

Parametrised dictionary write controller for the compressor's match stages. It generalises the two-lane write-control decode to NUM_LANES parallel words and registers the result behind a valid/ready handshake. It also owns the dictionary replacement pointer and fill level, and issues one write enable plus address per lane. It sits between the match/type-decode stage and the dictionary storage.

## Interface
- NUM_LANES, 2, parallel words per beat (1..8)
- TYPE_W, 2, width of per-lane match-type code
- DICT_DEPTH, 16, dictionary entries; power of two, ≥ NUM_LANES
- ADDR_W, $clog2(DICT_DEPTH), derived, not overridable
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  controller can accept a beat
- i_type_matched  in  NUM_LANES×TYPE_W  per-lane match type; 0 = no match
- i_match  in  NUM_LANES  per-lane hit from the earlier stage
- i_flush  in  1  clear dictionary state (pulse)
- i_freeze_on_full  in  1  1 = stop writing once full; 0 = round-robin overwrite
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output beat
- o_wr_en  out  NUM_LANES  per-lane dictionary write enable
- o_wr_addr  out  NUM_LANES×ADDR_W  per-lane write address
- o_wr_count  out  $clog2(NUM_LANES+1)  number of set o_wr_en bits
- o_fill_level  out  ADDR_W+1  valid entries, 0..DICT_DEPTH
- o_dict_full  out  1  o_fill_level == DICT_DEPTH

## Operation
- need[k] = (i_type_matched[k] == 0) & ~i_match[k].
- Lane k's rank = popcount(need[0..k-1]). Lane 0 has priority.
- Replacement pointer ptr is ADDR_W wide.
- Replace mode (i_freeze_on_full = 0): o_wr_en[k] = need[k]. o_wr_addr[k] = (ptr + rank[k]) mod DICT_DEPTH.
- Freeze mode (i_freeze_on_full = 1): a lane writes only if need[k] and fill + rank[k] < DICT_DEPTH. Lanes that fail this drop their write silently.
- Addresses of non-writing lanes are 0.
- On beat acceptance (i_valid & o_ready):
  - ptr += o_wr_count (wraps mod DICT_DEPTH).
  - fill = min(fill + o_wr_count, DICT_DEPTH).
- States:
  - FILLING: fill < DICT_DEPTH.
  - FULL: fill == DICT_DEPTH. In freeze mode, FULL produces all-zero o_wr_en while beats keep flowing.
  - FLUSH: entered for one cycle when i_flush is sampled high.
- Flush:
  - In the FLUSH cycle: ptr, fill and the output register clear, and o_ready = 0.
  - The next state is FILLING.
  - A beat presented in the same cycle as i_flush is not accepted.
- Handshake: o_ready = ~o_valid | i_ready, forced low in FLUSH. While o_valid & ~i_ready, the outputs hold stable.

## Timing
- Reset values:
  - o_valid = 0, o_wr_en = 0, o_wr_addr = 0, o_wr_count = 0.
  - o_fill_level = 0, o_dict_full = 0, ptr = 0.
  - State = FILLING. o_ready = 1 one cycle after reset release.
- Latency is 1 cycle: a beat accepted at edge n appears on o_wr_* and o_valid after edge n.
- o_fill_level and o_dict_full are registered. They reflect all beats accepted through the previous edge.
- Throughput is one beat per cycle when i_ready is held high.
- Fill and pointer updates of back-to-back beats chain correctly: beat n+1 uses the ptr/fill values updated by beat n.
- Asynchronous reset mid-beat drops the beat. No partial write is issued.

## Structure
- Package dict_ctrl_pkg holds:
  - the match-type enum, with TYPE_NONE = 0;
  - the state enum (FILLING, FULL, FLUSH);
  - a function that computes the popcount/rank vector.
- Sub-module lane_rank_prefix: purely combinational prefix popcount over NUM_LANES, producing rank[] and the total count.
- Top module: state register, ptr/fill counters, output register.

## Test plan
- Replace mode, NUM_LANES=2, DICT_DEPTH=16, ptr=0; lanes 0 and 1 both miss -> o_wr_en=11, addresses 0 and 1, o_wr_count=2, ptr=2 after accept, fill=2.
- Lane 0 type=1 (partial match), lane 1 miss, ptr=5 -> o_wr_en=10, lane 1 address 5, ptr becomes 6.
- Freeze mode, fill=15, both lanes miss -> only lane 0 writes (address 15), fill=16, o_dict_full=1. The next two-miss beat -> o_wr_en=00 and o_valid=1.
- Replace mode, ptr=15, both lanes miss -> addresses 15 and 0, ptr=1, fill saturates at 16.
- Downstream i_ready=0 for 3 cycles with a new beat waiting -> o_ready=0, outputs stable, ptr unchanged until release; then the next beat is accepted.
- i_flush together with i_valid at fill=9 -> beat not accepted, o_valid=0, fill=0, ptr=0 next cycle. Async reset asserted mid-stream -> all outputs 0 immediately.
